// File: rtl/fp_check_pkg.sv
// fp_check_pkg: shared types and helpers for the floating-point result checker.
//   NAN_S / NAN_D   : canonical quiet-NaN encodings for single and double.
//   fp_check_entry  : one queued expected result {result, flags, fmt, f2i}.
//                     The result field is always 64 bits; 32-bit builds zero-extend.
//   fp_masked_diff  : result XOR with the NaN payload hidden when the unit
//                     returns the canonical NaN.
package fp_check_pkg;

  localparam logic [31:0] NAN_S = 32'h7FC00000;
  localparam logic [63:0] NAN_D = 64'h7FF8000000000000;

  typedef struct packed {
    logic [63:0] result;
    logic [4:0]  flags;
    logic [1:0]  fmt;
    logic        f2i;
  } fp_check_entry;

  // When the unit produces the canonical NaN, only sign-independent exponent
  // and quiet bits are compared, so any expected NaN payload is accepted.
  // Float-to-int results are plain integers and never masked.
  function automatic logic [63:0] fp_masked_diff(input logic [1:0]  fmt,
                                                 input logic        f2i,
                                                 input logic [63:0] res,
                                                 input logic [63:0] exp);
    logic [63:0] d;
    d = res ^ exp;
    if (!f2i) begin
      if (fmt == 2'd0) begin
        if (res[31:0] == NAN_S)
          d = {32'h0, 1'b0, res[30:22] ^ exp[30:22], 22'h0};
      end else if (res == NAN_D) begin
        d = {1'b0, res[62:51] ^ exp[62:51], 51'h0};
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/fp_check_fifo.sv
// fp_check_fifo: synchronous FIFO of expected entries.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   push, pop    : requests; push is accepted when not full or when a pop
//                  happens in the same cycle, pop when not empty
//   wdata        : entry to enqueue
//   rdata        : head entry (combinational read of the storage array)
//   count        : registered occupancy, 0..DEPTH
//   full, empty  : registered status derived from the next occupancy
module fp_check_fifo
  import fp_check_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = fp_check_entry
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  T                       wdata,
  output T                       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T                mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;
  logic [CW-1:0]   count_next;

  // A full FIFO is never empty, so a pop frees the slot this push needs.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/fp_scoreboard.sv
// fp_scoreboard: in-order, latency-independent checker for fp_unit results.
//   clock, reset                    : rising-edge clock, sync active-high reset
//   issue_valid, exp_*              : expected entry pushed at issue
//   res_ready, res_result, res_flags: unit output compared against the head
//   count, full, empty              : queue occupancy
//   mismatch                        : one-cycle pulse per failing compare
//   err_sticky, overflow, underflow, halt : sticky status
//   err_count, chk_count            : saturating fail / compare counters
//   err_result_diff, err_flags_diff : diffs captured at the first failure
module fp_scoreboard
  import fp_check_pkg::*;
#(
  parameter int FLEN          = 64,
  parameter int DEPTH         = 8,
  parameter int CNTW          = 32,
  parameter int STOP_ON_ERROR = 1,
  parameter int NAN_MASK      = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   issue_valid,
  input  logic [FLEN-1:0]        exp_result,
  input  logic [4:0]             exp_flags,
  input  logic [1:0]             exp_fmt,
  input  logic                   exp_f2i,
  input  logic                   res_ready,
  input  logic [FLEN-1:0]        res_result,
  input  logic [4:0]             res_flags,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   mismatch,
  output logic                   err_sticky,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   halt,
  output logic [CNTW-1:0]        err_count,
  output logic [CNTW-1:0]        chk_count,
  output logic [FLEN-1:0]        err_result_diff,
  output logic [4:0]             err_flags_diff
);

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
    return (c == '1) ? c : c + CNTW'(1);
  endfunction

  fp_check_entry wr_entry;
  fp_check_entry head;
  logic [63:0]   res_ext;
  logic [63:0]   diff_p0;
  logic [4:0]    flag_diff_p0;
  logic          pop_p0;
  logic          fail_p0;

  assign wr_entry = '{result: 64'(exp_result), flags: exp_flags,
                      fmt: exp_fmt, f2i: exp_f2i};

  fp_check_fifo #(.DEPTH(DEPTH), .T(fp_check_entry)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (issue_valid),
    .pop   (res_ready),
    .wdata (wr_entry),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Stage p0: compare the head entry against the unit output.
  assign res_ext      = 64'(res_result);
  assign pop_p0       = res_ready && !empty;
  assign diff_p0      = (NAN_MASK != 0)
                        ? fp_masked_diff(head.fmt, head.f2i, res_ext, head.result)
                        : (res_ext ^ head.result);
  assign flag_diff_p0 = res_flags ^ head.flags;
  assign fail_p0      = pop_p0 && ((diff_p0 != '0) || (flag_diff_p0 != '0));

  // Stage p1: registered status, counters and first-error capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      mismatch        <= 1'b0;
      err_sticky      <= 1'b0;
      overflow        <= 1'b0;
      underflow       <= 1'b0;
      halt            <= 1'b0;
      err_count       <= '0;
      chk_count       <= '0;
      err_result_diff <= '0;
      err_flags_diff  <= '0;
    end else begin
      mismatch <= fail_p0;
      // A full queue always accepts a pop, so res_ready alone tells whether
      // the push is rescued.
      if (issue_valid && full && !res_ready) overflow <= 1'b1;
      if (res_ready && empty) underflow <= 1'b1;
      if (pop_p0) chk_count <= sat_inc(chk_count);
      if (fail_p0) begin
        err_count  <= sat_inc(err_count);
        err_sticky <= 1'b1;
        if (!err_sticky) begin
          err_result_diff <= diff_p0[FLEN-1:0];
          err_flags_diff  <= flag_diff_p0;
          if (STOP_ON_ERROR != 0) halt <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_scoreboard.sv
module tb_fp_scoreboard;

  localparam int FLEN  = 64;
  localparam int DEPTH = 8;
  localparam int CNTW  = 32;

  logic            clock;
  logic            reset;
  logic            issue_valid;
  logic [63:0]     exp_result;
  logic [4:0]      exp_flags;
  logic [1:0]      exp_fmt;
  logic            exp_f2i;
  logic            res_ready;
  logic [63:0]     res_result;
  logic [4:0]      res_flags;
  logic [3:0]      count;
  logic            full, empty, mismatch, err_sticky, overflow, underflow, halt;
  logic [CNTW-1:0] err_count, chk_count;
  logic [63:0]     err_result_diff;
  logic [4:0]      err_flags_diff;

  fp_scoreboard #(
    .FLEN(FLEN), .DEPTH(DEPTH), .CNTW(CNTW), .STOP_ON_ERROR(1), .NAN_MASK(1)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .issue_valid     (issue_valid),
    .exp_result      (exp_result),
    .exp_flags       (exp_flags),
    .exp_fmt         (exp_fmt),
    .exp_f2i         (exp_f2i),
    .res_ready       (res_ready),
    .res_result      (res_result),
    .res_flags       (res_flags),
    .count           (count),
    .full            (full),
    .empty           (empty),
    .mismatch        (mismatch),
    .err_sticky      (err_sticky),
    .overflow        (overflow),
    .underflow       (underflow),
    .halt            (halt),
    .err_count       (err_count),
    .chk_count       (chk_count),
    .err_result_diff (err_result_diff),
    .err_flags_diff  (err_flags_diff)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    res_ready   = 1'b0;
  endtask

  task automatic push_e(input logic [63:0] r, input logic [4:0] f,
                        input logic [1:0] fm, input logic fi);
    issue_valid = 1'b1; exp_result = r; exp_flags = f; exp_fmt = fm; exp_f2i = fi;
    step();
    issue_valid = 1'b0;
  endtask

  task automatic pop_r(input logic [63:0] r, input logic [4:0] f);
    res_ready = 1'b1; res_result = r; res_flags = f;
    step();
    res_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " count"},      64'(count),      64'd0);
    check({tag, " empty"},      64'(empty),      64'd1);
    check({tag, " full"},       64'(full),       64'd0);
    check({tag, " mismatch"},   64'(mismatch),   64'd0);
    check({tag, " err_sticky"}, 64'(err_sticky), 64'd0);
    check({tag, " overflow"},   64'(overflow),   64'd0);
    check({tag, " underflow"},  64'(underflow),  64'd0);
    check({tag, " halt"},       64'(halt),       64'd0);
    check({tag, " err_count"},  64'(err_count),  64'd0);
    check({tag, " chk_count"},  64'(chk_count),  64'd0);
    check({tag, " res_diff"},   err_result_diff, 64'd0);
    check({tag, " flags_diff"}, 64'(err_flags_diff), 64'd0);
  endtask

  typedef struct {
    logic [63:0] er;
    logic [4:0]  ef;
    logic [1:0]  fm;
    logic        fi;
    logic [63:0] rr;
    logic [4:0]  rf;
    logic        mis;
  } vec_t;

  vec_t        tbl [9];
  int          exp_err;
  int          rdy_q[$];
  logic [63:0] dat_q[$];
  int          issued, done, cyc;
  bit          do_push, do_pop;
  logic [63:0] dat;

  initial begin
    reset = 1'b0; issue_valid = 1'b0; res_ready = 1'b0;
    exp_result = '0; exp_flags = '0; exp_fmt = '0; exp_f2i = 1'b0;
    res_result = '0; res_flags = '0;

    tbl[0] = '{64'h0000_0000_7FC0_0001, 5'h00, 2'd0, 1'b0, 64'h0000_0000_7FC0_0000, 5'h00, 1'b0};
    tbl[1] = '{64'h7FF8_0000_0000_0001, 5'h00, 2'd1, 1'b0, 64'h7FF8_0000_0000_0000, 5'h00, 1'b0};
    tbl[2] = '{64'h3FF0_0000_0000_0000, 5'h05, 2'd1, 1'b0, 64'h3FF0_0000_0000_0000, 5'h05, 1'b0};
    tbl[3] = '{64'h1234_5678_7FC0_0000, 5'h00, 2'd0, 1'b0, 64'h0000_0000_7FC0_0000, 5'h00, 1'b0};
    tbl[4] = '{64'h0000_0000_7FC0_0001, 5'h00, 2'd0, 1'b1, 64'h0000_0000_7FC0_0000, 5'h00, 1'b1};
    tbl[5] = '{64'h0000_0000_7F80_0000, 5'h00, 2'd0, 1'b0, 64'h0000_0000_7FC0_0000, 5'h00, 1'b1};
    tbl[6] = '{64'h0000_0001_0000_0000, 5'h00, 2'd0, 1'b0, 64'h0000_0000_0000_0000, 5'h00, 1'b1};
    tbl[7] = '{64'h7FF0_0000_0000_0000, 5'h00, 2'd2, 1'b0, 64'h7FF8_0000_0000_0000, 5'h00, 1'b1};
    tbl[8] = '{64'h0000_0000_7FC0_0001, 5'h00, 2'd1, 1'b0, 64'h0000_0000_7FC0_0000, 5'h00, 1'b1};

    // Reset values
    do_reset();
    check_reset_state("rst");

    // Single-format pass
    for (int i = 0; i < 3; i++) push_e(64'h3F80_0000 + 64'(i), 5'(i), 2'd0, 1'b0);
    check("pass count3", 64'(count), 64'd3);
    for (int i = 0; i < 3; i++) pop_r(64'h3F80_0000 + 64'(i), 5'(i));
    check("pass chk", 64'(chk_count), 64'd3);
    check("pass err", 64'(err_count), 64'd0);
    check("pass empty", 64'(empty), 64'd1);

    // Table of compare vectors
    exp_err = 0;
    for (int i = 0; i < 9; i++) begin
      push_e(tbl[i].er, tbl[i].ef, tbl[i].fm, tbl[i].fi);
      pop_r(tbl[i].rr, tbl[i].rf);
      exp_err += int'(tbl[i].mis);
      check($sformatf("tbl%0d mismatch", i), 64'(mismatch), 64'(tbl[i].mis));
      check($sformatf("tbl%0d err_count", i), 64'(err_count), 64'(exp_err));
    end
    step();
    check("tbl mismatch drop", 64'(mismatch), 64'd0);
    check("tbl chk_count", 64'(chk_count), 64'd12);
    check("tbl first diff", err_result_diff, 64'h1);
    check("tbl first flags", 64'(err_flags_diff), 64'h0);
    check("tbl halt", 64'(halt), 64'd1);
    check("tbl sticky", 64'(err_sticky), 64'd1);

    // Double NaN with flag difference as first error
    do_reset();
    push_e(64'h7FF8_0000_0000_0001, 5'b00001, 2'd1, 1'b0);
    pop_r(64'h7FF8_0000_0000_0000, 5'b00000);
    check("dflag mismatch", 64'(mismatch), 64'd1);
    check("dflag flags_diff", 64'(err_flags_diff), 64'h01);
    check("dflag res_diff", err_result_diff, 64'h0);
    check("dflag halt", 64'(halt), 64'd1);

    // Full and overflow
    do_reset();
    for (int i = 0; i < 8; i++) push_e(64'h100 + 64'(i), 5'h0, 2'd1, 1'b0);
    check("full count", 64'(count), 64'd8);
    check("full flag", 64'(full), 64'd1);
    issue_valid = 1'b1; exp_result = 64'h200; exp_flags = 5'h0; exp_fmt = 2'd1; exp_f2i = 1'b0;
    res_ready = 1'b1; res_result = 64'h100; res_flags = 5'h0;
    step();
    idle();
    check("pushpop count", 64'(count), 64'd8);
    check("pushpop overflow", 64'(overflow), 64'd0);
    check("pushpop mismatch", 64'(mismatch), 64'd0);
    push_e(64'h300, 5'h0, 2'd1, 1'b0);
    check("ovf flag", 64'(overflow), 64'd1);
    check("ovf count", 64'(count), 64'd8);
    for (int i = 1; i < 8; i++) begin
      pop_r(64'h100 + 64'(i), 5'h0);
      check($sformatf("drain%0d mismatch", i), 64'(mismatch), 64'd0);
    end
    pop_r(64'h200, 5'h0);
    check("drain last mismatch", 64'(mismatch), 64'd0);
    check("drain empty", 64'(empty), 64'd1);
    check("drain chk", 64'(chk_count), 64'd9);
    pop_r(64'h300, 5'h0);
    check("ninth not compared", 64'(chk_count), 64'd9);
    check("ninth err", 64'(err_count), 64'd0);

    // Underflow with simultaneous push
    do_reset();
    issue_valid = 1'b1; exp_result = 64'h55; exp_flags = 5'h0; exp_fmt = 2'd1; exp_f2i = 1'b0;
    res_ready = 1'b1; res_result = 64'h55; res_flags = 5'h0;
    step();
    idle();
    check("udf flag", 64'(underflow), 64'd1);
    check("udf count", 64'(count), 64'd1);
    check("udf chk", 64'(chk_count), 64'd0);
    pop_r(64'h55, 5'h0);
    check("udf pop mismatch", 64'(mismatch), 64'd0);
    check("udf pop chk", 64'(chk_count), 64'd1);

    // Variable result latency
    do_reset();
    issued = 0; done = 0; cyc = 0;
    while (done < 12 && cyc < 2000) begin
      do_push = (issued < 12) && (rdy_q.size() < DEPTH) && ($urandom_range(0, 1) == 1);
      do_pop  = (rdy_q.size() > 0) && (rdy_q[0] <= cyc);
      dat = 64'hC0DE_0000_0000_0000 | 64'(issued);
      issue_valid = do_push;
      exp_result  = dat; exp_flags = dat[4:0]; exp_fmt = 2'd1; exp_f2i = 1'b0;
      res_ready   = do_pop;
      if (do_pop) begin
        res_result = dat_q[0];
        res_flags  = dat_q[0][4:0];
      end
      step();
      if (do_pop) begin
        check($sformatf("lat%0d mismatch", done), 64'(mismatch), 64'd0);
        void'(rdy_q.pop_front());
        void'(dat_q.pop_front());
        done++;
      end
      if (do_push) begin
        rdy_q.push_back(cyc + int'($urandom_range(1, 20)));
        dat_q.push_back(dat);
        issued++;
      end
      cyc++;
    end
    idle();
    check("lat done", 64'(done), 64'd12);
    check("lat err", 64'(err_count), 64'd0);
    check("lat chk", 64'(chk_count), 64'd12);
    check("lat empty", 64'(empty), 64'd1);

    // Reset with entries in flight, colliding with push and pop
    for (int i = 0; i < 4; i++) push_e(64'h900 + 64'(i), 5'h0, 2'd1, 1'b0);
    check("inflight count", 64'(count), 64'd4);
    reset = 1'b1;
    issue_valid = 1'b1; exp_result = 64'hAAA; res_ready = 1'b1; res_result = 64'hBBB;
    step();
    reset = 1'b0;
    idle();
    check_reset_state("midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
